// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative shift-add MUL.
// Define ALU_ITER_DIV_EN to add restoring UDIV (op 1001); otherwise 1001 is reserved.
module alu_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUControl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_ORR = 4'b0011;
  localparam logic [3:0] OP_EOR = 4'b0100;
  localparam logic [3:0] OP_MOV = 4'b0101;
  localparam logic [3:0] OP_MUL = 4'b1000;
`ifdef ALU_ITER_DIV_EN
  localparam logic [3:0] OP_UDIV = 4'b1001;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_x, w_x_nxt;      // multiplicand / quotient shift register
  logic [WIDTH-1:0] r_y, w_y_nxt;      // multiplier / divisor
  logic [WIDTH-1:0] r_acc, w_acc_nxt;  // product accumulator / partial remainder
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic [3:0]       r_flags, w_flags_nxt;

  logic             w_sub;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_sc_res;
  logic [3:0]       w_sc_flags;
  logic             w_iter_op;
  logic [WIDTH-1:0] w_step_acc, w_step_x, w_step_y, w_iter_res;

`ifdef ALU_ITER_DIV_EN
  logic             r_div, w_div_nxt;
  logic [WIDTH:0]   w_rem_sh, w_diff;
  logic             w_ge;
  assign w_iter_op = (ALUControl == OP_MUL) || (ALUControl == OP_UDIV);
`else
  assign w_iter_op = (ALUControl == OP_MUL);
`endif

  // Single-cycle datapath and flags
  always_comb begin
    w_sub      = (ALUControl == OP_SUB);
    w_sum      = {1'b0, a} + {1'b0, (w_sub ? ~b : b)} + (WIDTH+1)'(w_sub);
    w_sc_res   = '0;
    w_sc_flags = '0;
    case (ALUControl)
      OP_ADD, OP_SUB: begin
        w_sc_res      = w_sum[WIDTH-1:0];
        w_sc_flags[1] = w_sum[WIDTH];
        w_sc_flags[0] = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ w_sub) & (a[WIDTH-1] ^ w_sum[WIDTH-1]);
      end
      OP_AND:  w_sc_res = a & b;
      OP_ORR:  w_sc_res = a | b;
      OP_EOR:  w_sc_res = a ^ b;
      OP_MOV:  w_sc_res = b;
      default: w_sc_res = '0;
    endcase
    w_sc_flags[3] = w_sc_res[WIDTH-1];
    w_sc_flags[2] = (w_sc_res == '0);
  end

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
`ifdef ALU_ITER_DIV_EN
    w_rem_sh = {r_acc, r_x[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_y};
    w_ge     = ~w_diff[WIDTH];
    if (r_div) begin
      w_step_acc = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
      w_step_x   = {r_x[WIDTH-2:0], w_ge};
      w_step_y   = r_y;
      w_iter_res = (r_y == '0) ? '0 : w_step_x;
    end else begin
      w_step_acc = r_y[0] ? (r_acc + r_x) : r_acc;
      w_step_x   = r_x << 1;
      w_step_y   = r_y >> 1;
      w_iter_res = w_step_acc;
    end
`else
    w_step_acc = r_y[0] ? (r_acc + r_x) : r_acc;
    w_step_x   = r_x << 1;
    w_step_y   = r_y >> 1;
    w_iter_res = w_step_acc;
`endif
  end

  // Next-state and output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_acc_nxt    = r_acc;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_result_nxt = r_result;
    w_flags_nxt  = r_flags;
`ifdef ALU_ITER_DIV_EN
    w_div_nxt    = r_div;
`endif
    case (r_state)
      S_ITER: begin
        w_acc_nxt = w_step_acc;
        w_x_nxt   = w_step_x;
        w_y_nxt   = w_step_y;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_state_nxt  = S_FIN;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_result_nxt = w_iter_res;
          w_flags_nxt  = {w_iter_res[WIDTH-1], (w_iter_res == '0), 2'b00};
        end
      end
      default: begin
        // IDLE and FIN both accept a new request
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        if (start) begin
          if (w_iter_op) begin
            w_state_nxt = S_ITER;
            w_busy_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_x_nxt     = a;
            w_y_nxt     = b;
            w_acc_nxt   = '0;
`ifdef ALU_ITER_DIV_EN
            w_div_nxt   = (ALUControl == OP_UDIV);
`endif
          end else begin
            w_done_nxt   = 1'b1;
            w_result_nxt = w_sc_res;
            w_flags_nxt  = w_sc_flags;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
`ifdef ALU_ITER_DIV_EN
      r_div    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_acc    <= w_acc_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
      r_flags  <= w_flags_nxt;
`ifdef ALU_ITER_DIV_EN
      r_div    <= w_div_nxt;
`endif
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign Result   = r_result;
  assign ALUFlags = r_flags;

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter (WIDTH=32); follows ALU_ITER_DIV_EN if defined.
module tb_alu_iter;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  a, b;
  logic [3:0]    op;
  logic          busy, done;
  logic [W-1:0]  res;
  logic [3:0]    flags;

  int n_chk  = 0;
  int n_fail = 0;

  alu_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ALUControl(op),
    .busy(busy), .done(done), .Result(res), .ALUFlags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request during cycle t; returns in cycle t+1
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Latency in cycles from the start cycle to done (bounded)
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 80) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 4'h0; a = '0; b = '0;
    tick(); tick();
    reset = 1'b0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_chk++; if (res !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h exp 0", res); end
    n_chk++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", flags); end
  endtask

  task automatic test_addsub();
    logic [3:0]   ops [3] = '{4'b0000, 4'b0001, 4'b0001};
    logic [W-1:0] xa  [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd5};
    logic [W-1:0] xb  [3] = '{32'h0000_0001, 32'h0000_0001, 32'd7};
    logic [W-1:0] er  [3] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
    logic [3:0]   ef  [3] = '{4'b0110, 4'b0011, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], xa[i], xb[i]);
      n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL addsub_done[%0d] got %b exp 1", i, done); end
      n_chk++; if (res !== er[i]) begin n_fail++; $display("FAIL addsub_result[%0d] got %h exp %h", i, res, er[i]); end
      n_chk++; if (flags !== ef[i]) begin n_fail++; $display("FAIL addsub_flags[%0d] got %b exp %b", i, flags, ef[i]); end
      tick();
      n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL addsub_pulse[%0d] got %b exp 0", i, done); end
    end
  endtask

  task automatic test_logic();
    logic [3:0]   ops [5] = '{4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0111};
    logic [W-1:0] xa  [5] = '{32'hF0F0_1234, 32'h0000_00F0, 32'hA5A5_A5A5, 32'h1111_1111, 32'h1234_5678};
    logic [W-1:0] xb  [5] = '{32'h0F0F_FF00, 32'h8000_000F, 32'hA5A5_A5A5, 32'h8000_0000, 32'h9ABC_DEF0};
    logic [W-1:0] er  [5] = '{32'h0000_1200, 32'h8000_00FF, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
    logic [3:0]   ef  [5] = '{4'b0000, 4'b1000, 4'b0100, 4'b1000, 4'b0100};
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], xa[i], xb[i]);
      n_chk++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL logic_hs[%0d] got done=%b busy=%b exp 1/0", i, done, busy); end
      n_chk++; if (res !== er[i]) begin n_fail++; $display("FAIL logic_result[%0d] got %h exp %h", i, res, er[i]); end
      n_chk++; if (flags !== ef[i]) begin n_fail++; $display("FAIL logic_flags[%0d] got %b exp %b", i, flags, ef[i]); end
    end
    tick();
  endtask

  task automatic test_mul_busy();
    issue(4'b1000, 32'h0001_0003, 32'h0000_0005);
    for (int c = 1; c <= 32; c++) begin
      n_chk++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL mul_busy[t+%0d] got busy=%b done=%b exp 1/0", c, busy, done); end
      if (c == 5) begin
        op = 4'b0000; a = 32'd1; b = 32'd1; start = 1'b1;
        tick();
        start = 1'b0; op = 4'b0101; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
      end else begin
        tick();
      end
    end
    n_chk++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mul_done_t33 got done=%b busy=%b exp 1/0", done, busy); end
    n_chk++; if (res !== 32'h0005_000F) begin n_fail++; $display("FAIL mul_result got %h exp 0005000f", res); end
    n_chk++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL mul_flags got %b exp 0000", flags); end
    tick();
    n_chk++; if (done !== 1'b0 || res !== 32'h0005_000F) begin n_fail++; $display("FAIL mul_dropped_add got done=%b result=%h exp 0/0005000f", done, res); end
  endtask

  task automatic test_mul_overflow();
    int lat;
    issue(4'b1000, 32'h0001_0000, 32'h0001_0000);
    wait_done(lat);
    n_chk++; if (lat != 33) begin n_fail++; $display("FAIL mulov_latency got %0d exp 33", lat); end
    n_chk++; if (res !== 32'h0 || flags !== 4'b0100) begin n_fail++; $display("FAIL mulov_result got %h/%b exp 0/0100", res, flags); end
    tick();
  endtask

  task automatic test_udiv();
    int lat;
`ifdef ALU_ITER_DIV_EN
    issue(4'b1001, 32'd100, 32'd7);
    wait_done(lat);
    n_chk++; if (lat != 33) begin n_fail++; $display("FAIL udiv_latency got %0d exp 33", lat); end
    n_chk++; if (res !== 32'd14 || flags !== 4'b0000) begin n_fail++; $display("FAIL udiv_result got %h/%b exp 0000000e/0000", res, flags); end
    tick();
    issue(4'b1001, 32'd100, 32'd0);
    wait_done(lat);
    n_chk++; if (lat != 33) begin n_fail++; $display("FAIL udiv0_latency got %0d exp 33", lat); end
    n_chk++; if (res !== 32'd0 || flags !== 4'b0100) begin n_fail++; $display("FAIL udiv0_result got %h/%b exp 0/0100", res, flags); end
    tick();
`else
    issue(4'b1001, 32'd100, 32'd7);
    lat = 0;
    n_chk++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL udivoff_hs got done=%b busy=%b exp 1/0", done, busy); end
    n_chk++; if (res !== 32'd0 || flags !== 4'b0100) begin n_fail++; $display("FAIL udivoff_result got %h/%b exp 0/0100 (lat %0d)", res, flags, lat); end
    tick();
`endif
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(4'b1000, 32'd3, 32'd4);
    wait_done(lat);
    n_chk++; if (lat != 33) begin n_fail++; $display("FAIL b2b_mul_latency got %0d exp 33", lat); end
    n_chk++; if (res !== 32'd12) begin n_fail++; $display("FAIL b2b_mul_result got %h exp 0000000c", res); end
    issue(4'b0011, 32'h0000_00F0, 32'h0000_000F);
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_orr_done got %b exp 1", done); end
    n_chk++; if (res !== 32'h0000_00FF || flags !== 4'b0000) begin n_fail++; $display("FAIL b2b_orr_result got %h/%b exp 000000ff/0000", res, flags); end
    tick();
  endtask

  task automatic test_reset_abort();
    logic seen_done;
    issue(4'b1000, 32'h0001_0003, 32'h0000_0005);
    for (int c = 1; c < 10; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_hs got busy=%b done=%b exp 0/0", busy, done); end
    n_chk++; if (res !== 32'h0 || flags !== 4'b0000) begin n_fail++; $display("FAIL abort_state got %h/%b exp 0/0000", res, flags); end
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
      tick();
    end
    n_chk++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got %b exp 0", seen_done); end
    issue(4'b0000, 32'd2, 32'd3);
    n_chk++; if (done !== 1'b1 || res !== 32'd5 || flags !== 4'b0000) begin n_fail++; $display("FAIL abort_add got done=%b result=%h flags=%b exp 1/00000005/0000", done, res, flags); end
    tick();
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_logic();
    test_mul_busy();
    test_mul_overflow();
    test_udiv();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
